priority_encoder_4to2: RTL and testbench

Debounced, registered 4-to-2 priority encoder: the encoding counterpart of the team's 2-to-4 decoder. Samples four asynchronous request lines (buttons, switches, or status flags), synchronizes and debounces them as a group, and presents the highest-priority active line as a 2-bit code. Each new press is also issued as a one-entry valid/ready event toward downstream logic, e.g. a display driver or a control FSM.

---
 rtl/priority_encoder_4to2.sv | 94 +++++++++
 tb/tb_priority_encoder_4to2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_4to2.sv
// Debounced, registered 4-to-2 priority encoder with a one-entry press-event slot.
// Request lines are synchronized, debounced as a group, then priority-encoded.
module priority_encoder_4to2 #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [1:0] code,
  output logic       active,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [1:0] prio_code(input logic [3:0] v);
    if (v[3])      prio_code = 2'd3;
    else if (v[2]) prio_code = 2'd2;
    else if (v[1]) prio_code = 2'd1;
    else           prio_code = 2'd0;
  endfunction

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       stable;

  logic load_stable;
  logic press;
  logic accept;
  logic slot_free;

  always_comb begin
    load_stable = (sync2 == cand) && (cnt == CNT_LOAD);
    // A press needs a nonzero new vector whose top bit moved (or came from idle).
    press       = load_stable && (|cand) &&
                  ((~|stable) || (prio_code(cand) != prio_code(stable)));
    accept      = evt_valid & evt_ready;
    slot_free   = ~evt_valid | evt_ready;
  end

  // Synchronizer and debounce stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
        if (cnt == CNT_LOAD) stable <= cand;
      end
    end
  end

  // Event slot stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      overflow  <= 1'b0;
    end else begin
      if (press) begin
        if (slot_free) begin
          evt_valid <= 1'b1;
          evt_code  <= prio_code(cand);
        end
      end else if (accept) begin
        evt_valid <= 1'b0;
      end
      if (press && !slot_free) overflow <= 1'b1;
      else if (ovf_clr)        overflow <= 1'b0;
    end
  end

  assign code   = prio_code(stable);
  assign active = |stable;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Scoreboard bench for priority_encoder_4to2: directed scenarios plus random
// request traffic, checked against a run-length debounce reference model.
module tb_priority_encoder_4to2;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in = 4'd0;
  logic [1:0] code;
  logic       active;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready = 1'b1;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  priority_encoder_4to2 #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .code(code), .active(active),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Highest set bit index = floor(log2(v)) for v > 0.
  function automatic int ref_code(input logic [3:0] v);
    int x;
    x = int'(v);
    return (x == 0) ? 0 : $clog2(x + 1) - 1;
  endfunction

  // Reference model: in sampled per edge; the debounced vector adopts a value
  // once the two-edge-delayed input has been seen on DEB+1 consecutive edges.
  logic [3:0] hist[$];
  logic [3:0] run_val  = 4'd0;
  int         run_len  = 1;
  logic [3:0] m_stable = 4'd0;
  logic       m_valid  = 1'b0;
  logic [1:0] m_code   = 2'd0;
  logic       m_ovf    = 1'b0;
  int         sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      sb.delete();
      run_val  <= 4'd0;
      run_len  = 1;
      m_stable <= 4'd0;
      m_valid  <= 1'b0;
      m_code   <= 2'd0;
      m_ovf    <= 1'b0;
    end else begin
      logic [3:0] seen;
      logic [3:0] nv;
      logic       prs;
      logic       drop;
      logic       nvalid;
      logic [1:0] ncode;
      // Monitor: consumer handshake on this edge retires the oldest event.
      if (evt_valid && evt_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_event", 1, 0);
        else chk("sb_evt_code", int'(evt_code), sb.pop_front());
      end
      seen = (hist.size() >= 2) ? hist[hist.size()-2] : 4'd0;
      hist.push_back(in);
      if (hist.size() > 4) void'(hist.pop_front());
      nv = m_stable;
      prs = 1'b0;
      if (seen == run_val) run_len = (run_len > 1000) ? run_len : run_len + 1;
      else begin
        run_val <= seen;
        run_len = 1;
      end
      if (run_len == DEB + 1) begin
        nv  = seen;
        prs = (nv != 0) && (m_stable == 0 || ref_code(nv) != ref_code(m_stable));
      end
      drop = 1'b0;
      nvalid = m_valid;
      ncode = m_code;
      if (prs) begin
        if (!m_valid || evt_ready) begin
          nvalid = 1'b1;
          ncode  = 2'(ref_code(nv));
          sb.push_back(ref_code(nv));
        end else drop = 1'b1;
      end else if (m_valid && evt_ready) nvalid = 1'b0;
      m_stable <= nv;
      m_valid  <= nvalid;
      m_code   <= ncode;
      if (drop)         m_ovf <= 1'b1;
      else if (ovf_clr) m_ovf <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("code",      int'(code),      ref_code(m_stable));
      chk("active",    int'(active),    int'(m_stable != 0));
      chk("evt_valid", int'(evt_valid), int'(m_valid));
      if (m_valid) chk("evt_code", int'(evt_code), int'(m_code));
      chk("overflow",  int'(overflow),  int'(m_ovf));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_code"},      int'(code),      0);
    chk({tag, "_active"},    int'(active),    0);
    chk({tag, "_evt_valid"}, int'(evt_valid), 0);
    chk({tag, "_evt_code"},  int'(evt_code),  0);
    chk({tag, "_overflow"},  int'(overflow),  0);
  endtask

  // Drives a vector right after a falling edge and returns the rising edge
  // (counted from 1) on which active first appears, 0 if never within 12.
  task automatic measure_latency(input logic [3:0] v, output int edge_no);
    edge_no = 0;
    in = v;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (active && edge_no == 0) edge_no = k;
    end
  endtask

  initial begin
    int lat;
    #2;
    check_outputs_zero("reset");
    cycles(2);
    rst_n = 1'b1;
    cycles(8);

    // Clean press: everything appears exactly DEB+3 edges after the change.
    measure_latency(4'b0100, lat);
    chk("latency_press", lat, DEB + 3);
    chk("press_code", int'(code), 2);

    // Release, then a glitch too short to be accepted.
    in = 4'b0000; cycles(10);
    in = 4'b0001; cycles(3);
    in = 4'b0000; cycles(10);
    chk("glitch_active", int'(active), 0);

    // Lower-priority bit joins without an event; then top bit drops.
    in = 4'b1000; cycles(10);
    in = 4'b1010; cycles(10);
    chk("add_low_code", int'(code), 3);
    in = 4'b0010; cycles(10);
    chk("drop_high_code", int'(code), 1);

    // Overflow: one pending event, a second press dropped.
    evt_ready = 1'b0;
    in = 4'b0001; cycles(10);
    in = 4'b0000; cycles(10);
    in = 4'b0100; cycles(10);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_evt_code", int'(evt_code), 0);
    ovf_clr = 1'b1; cycles(1); ovf_clr = 1'b0; cycles(1);
    chk("ovf_cleared", int'(overflow), 0);
    evt_ready = 1'b1; cycles(1); evt_ready = 1'b0; cycles(1);
    chk("accepted_empty", int'(evt_valid), 0);

    // Accept and load on the same edge: no bubble, no overflow.
    in = 4'b0010; cycles(10);
    chk("pending_code1", int'(evt_code), 1);
    in = 4'b1000; cycles(6);
    evt_ready = 1'b1; cycles(1);
    evt_ready = 1'b0;
    chk("simul_valid", int'(evt_valid), 1);
    chk("simul_code", int'(evt_code), 3);
    chk("simul_ovf", int'(overflow), 0);
    cycles(2);

    // Asynchronous reset mid-debounce with an event pending.
    in = 4'b0001; cycles(10);
    in = 4'b0100; cycles(3);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    cycles(2);
    rst_n = 1'b1;
    measure_latency(4'b0100, lat);
    chk("latency_after_reset", lat, DEB + 3);
    evt_ready = 1'b1;
    cycles(2);

    // Random traffic.
    for (int s = 0; s < 60; s++) begin
      in = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        ovf_clr   = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
    end
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    cycles(20);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
